// File: rtl/karatsuba64_seq_ctrl_pkg.sv
// Shared types and constants for the sequential Karatsuba 64x64 multiplier controller.
// The controller also honours the optional build macro KARA_MUL_PIPE_EN.
package karatsuba_pkg;

  localparam int KARA_W     = 64;
  localparam int KARA_HW    = 32;
  localparam int KARA_MW    = 34;
  localparam int KARA_SH_LO = 32;
  localparam int KARA_SH_HI = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_MID,
    ST_COMB,
    ST_DONE
  } kara_state_t;

endpackage

// File: rtl/karatsuba64_seq_ctrl_if.sv
// Operand/result handshake bundle for karatsuba64_seq_ctrl.
// The slave side is the controller; the master side is the operand source plus the result sink.
interface karatsuba64_seq_ctrl_if #(
  parameter int W = 64
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p
  );
endinterface

// File: rtl/karatsuba64_seq_ctrl_combine.sv
// Purely combinational Karatsuba recombination: p = (z2<<64) + ((z1-z2-z0)<<32) + z0, all mod 2^N.
// It is kept standalone so that a fully parallel variant can reuse it.
module karatsuba_combine
  import karatsuba_pkg::*;
#(
  parameter int W  = KARA_W,
  parameter int MW = KARA_MW
) (
  input  logic [2*MW-1:0] z0,
  input  logic [2*MW-1:0] z1,
  input  logic [2*MW-1:0] z2,
  output logic [2*W-1:0]  p
);

  logic [2*MW-1:0] zm;
  logic [2*W-1:0]  z0_x;
  logic [2*W-1:0]  zm_x;
  logic [2*W-1:0]  z2_x;

  always_comb begin
    // The middle term is formed modulo 2^(2*MW); a wrap here cancels out in the final sum.
    zm   = z1 - z2 - z0;
    z0_x = (2*W)'(z0);
    zm_x = (2*W)'(zm) << KARA_SH_LO;
    z2_x = (2*W)'(z2) << KARA_SH_HI;
    p    = z2_x + zm_x + z0_x;
  end

endmodule

// File: rtl/karatsuba64_seq_ctrl.sv
// Sequential 64x64 Karatsuba controller sharing one external multiplier over the z0/z2/z1 products.
// Optional macro KARA_MUL_PIPE_EN registers mul_p and turns each multiply state into issue+capture.
module karatsuba64_seq_ctrl
  import karatsuba_pkg::*;
#(
  parameter int W  = KARA_W,
  parameter int MW = KARA_MW
) (
  input  logic                    clk,
  input  logic                    rst,
  karatsuba64_seq_ctrl_if.slave   bus,
  output logic [MW-1:0]           mul_a,
  output logic [MW-1:0]           mul_b,
  input  logic [2*MW-1:0]         mul_p,
  output logic                    busy
);

  localparam int HW = W / 2;

  kara_state_t     state_q, state_d;
  logic [HW-1:0]   xl_q, xl_d, xh_q, xh_d;
  logic [HW-1:0]   yl_q, yl_d, yh_q, yh_d;
  logic [2*MW-1:0] z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;
  logic [2*W-1:0]  out_p_q, out_p_d;
  logic [2*W-1:0]  comb_p;
  logic [HW:0]     x_sum, y_sum;
  logic [2*MW-1:0] prod;
  logic            cap;

`ifdef KARA_MUL_PIPE_EN
  logic [2*MW-1:0] mulp_q, mulp_d;
  logic            phase_q, phase_d;
`endif

  karatsuba_combine #(
    .W  (W),
    .MW (MW)
  ) u_combine (
    .z0 (z0_q),
    .z1 (z1_q),
    .z2 (z2_q),
    .p  (comb_p)
  );

  always_comb begin
    x_sum = {1'b0, xl_q} + {1'b0, xh_q};
    y_sum = {1'b0, yl_q} + {1'b0, yh_q};
  end

`ifdef KARA_MUL_PIPE_EN
  // Capture happens on the second cycle of each multiply state, from the registered product.
  always_comb begin
    mulp_d = mul_p;
    prod   = mulp_q;
    cap    = phase_q;
  end
`else
  always_comb begin
    prod = mul_p;
    cap  = 1'b1;
  end
`endif

  always_comb begin
    state_d = state_q;
    xl_d    = xl_q;
    xh_d    = xh_q;
    yl_d    = yl_q;
    yh_d    = yh_q;
    z0_d    = z0_q;
    z1_d    = z1_q;
    z2_d    = z2_q;
    out_p_d = out_p_q;
    mul_a   = '0;
    mul_b   = '0;
`ifdef KARA_MUL_PIPE_EN
    phase_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          xl_d    = bus.in_x[HW-1:0];
          xh_d    = bus.in_x[W-1:HW];
          yl_d    = bus.in_y[HW-1:0];
          yh_d    = bus.in_y[W-1:HW];
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        mul_a = MW'(xl_q);
        mul_b = MW'(yl_q);
`ifdef KARA_MUL_PIPE_EN
        phase_d = ~phase_q;
`endif
        if (cap) begin
          z0_d    = prod;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        mul_a = MW'(xh_q);
        mul_b = MW'(yh_q);
`ifdef KARA_MUL_PIPE_EN
        phase_d = ~phase_q;
`endif
        if (cap) begin
          z2_d    = prod;
          state_d = ST_MID;
        end
      end
      ST_MID: begin
        // The 33-bit half sums keep their carry, hence the wider multiplier port.
        mul_a = MW'(x_sum);
        mul_b = MW'(y_sum);
`ifdef KARA_MUL_PIPE_EN
        phase_d = ~phase_q;
`endif
        if (cap) begin
          z1_d    = prod;
          state_d = ST_COMB;
        end
      end
      ST_COMB: begin
        out_p_d = comb_p;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xl_q    <= '0;
      xh_q    <= '0;
      yl_q    <= '0;
      yh_q    <= '0;
      z0_q    <= '0;
      z1_q    <= '0;
      z2_q    <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      xl_q    <= xl_d;
      xh_q    <= xh_d;
      yl_q    <= yl_d;
      yh_q    <= yh_d;
      z0_q    <= z0_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      out_p_q <= out_p_d;
    end
  end

`ifdef KARA_MUL_PIPE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mulp_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      mulp_q  <= mulp_d;
      phase_q <= phase_d;
    end
  end
`endif

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_p     = out_p_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_karatsuba64_seq_ctrl.sv
// Directed scoreboard bench for karatsuba64_seq_ctrl with an exact multiplier model.
module tb_karatsuba64_seq_ctrl;

`ifdef KARA_MUL_PIPE_EN
  localparam int LAT     = 7;
  localparam int MID_IDX = 4;
  localparam int HI_OFS  = 2;
`else
  localparam int LAT     = 4;
  localparam int MID_IDX = 2;
  localparam int HI_OFS  = 1;
`endif

  logic         clk;
  logic         rst;
  logic [33:0]  mul_a;
  logic [33:0]  mul_b;
  logic [67:0]  mul_p;
  logic         busy;

  int checks;
  int failures;
  logic [127:0] exp_q[$];

  karatsuba64_seq_ctrl_if #(.W(64)) bus ();

  karatsuba64_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy)
  );

  assign mul_p = 68'(mul_a) * 68'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops an expected product at every result handshake.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", bus.out_p, 128'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_p", bus.out_p, e);
        end
      end
    end
  end

  task automatic do_op(input logic [63:0] x, input logic [63:0] y, input logic [127:0] e,
                       input logic [33:0] sa, input logic [33:0] sb, input int hold,
                       input string name);
    logic [33:0] ra[16];
    logic [33:0] rb[16];
    int          n;
    int          lat;
    logic        rdy_seen;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk({name, "_accept_timeout"}, 128'(bus.in_ready), 128'h1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    lat      = 0;
    ra[0]    = mul_a;
    rb[0]    = mul_b;
    rdy_seen = bus.in_ready;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat < 16) begin
        ra[lat] = mul_a;
        rb[lat] = mul_b;
      end
      if (bus.in_ready) rdy_seen = 1'b1;
    end
    chk({name, "_latency"}, 128'(lat), 128'(LAT));
    chk({name, "_in_ready_low"}, 128'(rdy_seen), 128'h0);
    chk({name, "_lo_a"}, 128'(ra[0]), 128'(x[31:0]));
    chk({name, "_mid_a"}, 128'(ra[MID_IDX]), 128'(sa));
    chk({name, "_mid_b"}, 128'(rb[MID_IDX]), 128'(sb));
`ifdef KARA_MUL_PIPE_EN
    chk({name, "_lo_a_hold"}, 128'(ra[1]), 128'(x[31:0]));
    chk({name, "_mid_a_hold"}, 128'(ra[MID_IDX+1]), 128'(sa));
    chk({name, "_mid_b_hold"}, 128'(rb[MID_IDX+1]), 128'(sb));
`endif
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 64'hDEAD_BEEF_0000_0011;
      bus.in_y     = 64'h0000_0022_CAFE_F00D;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        chk({name, "_stall_valid"}, 128'(bus.out_valid), 128'h1);
        chk({name, "_stall_p"}, bus.out_p, e);
        chk({name, "_stall_in_ready"}, 128'(bus.in_ready), 128'h0);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({name, "_post_in_ready"}, 128'(bus.in_ready), 128'h1);
    chk({name, "_post_out_valid"}, 128'(bus.out_valid), 128'h0);
    chk({name, "_post_busy"}, 128'(busy), 128'h0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'h1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'h0);
    chk("rst_out_p", bus.out_p, 128'h0);
    chk("rst_mul_a", 128'(mul_a), 128'h0);
    chk("rst_mul_b", 128'(mul_b), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);

    // Reset together with in_valid must not accept the operands.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 64'd9;
    bus.in_y     = 64'd9;
    @(posedge clk);
    #1;
    chk("rst_vs_valid_busy", 128'(busy), 128'h0);
    chk("rst_vs_valid_ready", 128'(bus.in_ready), 128'h1);
    bus.in_valid = 1'b0;
    rst          = 1'b0;

    do_op(64'h3, 64'h5, 128'hF, 34'h3, 34'h5, 0, "small");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 34'h1_FFFF_FFFE, 34'h1_FFFF_FFFE, 0, "allones");
    do_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
          128'h0000_0000_0000_0001_0000_0000_0000_0000, 34'h1, 34'h1, 0, "hi_only");
    do_op(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
          128'h0000_0000_0000_0001_0000_0002_0000_0001, 34'h2, 34'h2, 10, "stall");
    do_op(64'hFFFF_FFFF_0000_0000, 64'h2,
          128'h0000_0000_0000_0001_FFFF_FFFE_0000_0000, 34'hFFFF_FFFF, 34'h2, 0, "mixed");

    // Abort an operation while it is in HI.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 64'h0000_0055_0000_0077;
    bus.in_y     = 64'h0000_0066_0000_0088;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (HI_OFS) @(posedge clk);
    #1;
    chk("abort_in_hi_mul_a", 128'(mul_a), 128'h55);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_out_valid", 128'(bus.out_valid), 128'h0);
    chk("abort_mul_a", 128'(mul_a), 128'h0);
    chk("abort_in_ready", 128'(bus.in_ready), 128'h1);

    do_op(64'h2, 64'h7, 128'hE, 34'h2, 34'h7, 0, "after_abort");

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
